spi_shift_master: RTL and testbench
===================================

SPI_SHIFT_MASTER -- requirements
Module: spi_shift_master

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CLK_DIV, default 4: clock cycles per SCLK half-period, minimum 2.
REQ-003 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: a shift request is present.
REQ-006 SHALL have port req_ready, output, 1: a request can be accepted (high only in IDLE).
REQ-007 SHALL have port op_a, input, REG_WIDTH: operand to shift.
REQ-008 SHALL have port nbits, input, 5: shift amount.
REQ-009 SHALL have port mode, input, 3: shift mode (0 LSL, 1 LSR, 2 ASL, 3 ASR, 4 ROL, 5 ROR).
REQ-010 SHALL have port resp_valid, output, 1: one-cycle pulse marking a completed response.
REQ-011 SHALL have port result, output, REG_WIDTH: result read back from the slave, held until the next response.
REQ-012 SHALL have port err, output, 1: response is for an invalid mode, qualified by resp_valid.
REQ-013 SHALL have ports sclk (output, 1), cs_n (output, 1), mosi (output, 1) and miso (input, 1) forming the SPI master interface.

Function
REQ-014 SHALL accept a request on a clock edge where req_valid and req_ready are both high, and SHALL latch op_a, nbits and mode on that edge.
REQ-015 SHALL use SPI mode 0: sclk idles low; mosi changes after falling edges; miso is sampled on rising edges.
REQ-016 SHALL send each frame as 72 SCLK periods: 8-bit header {mode, nbits} MSB first, then op_a MSB first (40 bits total), then 32 read periods.
REQ-017 SHALL drive mosi low during read periods and shift miso MSB first into result.
REQ-018 SHALL run the FSM IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> RESP -> IDLE.
REQ-019 SHALL drive cs_n low on entry to CS_SETUP, which lasts CLK_DIV cycles, with mosi already set to the header MSB.
REQ-020 SHALL spend 144*CLK_DIV cycles in SHIFT, then CLK_DIV cycles in CS_HOLD with sclk low and cs_n low.
REQ-021 SHALL raise cs_n and pulse resp_valid for one cycle in RESP, at 146*CLK_DIV+1 cycles after the accept edge.
REQ-022 SHALL update result only in RESP, so that result never shows partial shift data.
REQ-023 SHALL treat mode 6 or 7 as invalid: accept the request, start no SPI frame (cs_n stays high), and in the next cycle pulse resp_valid with err=1 and result=0.
REQ-024 SHALL keep req_ready low from the accept edge through RESP, so a back-to-back request is accepted no earlier than the cycle after RESP.
REQ-025 SHALL transmit nbits=0 unchanged; shift semantics belong to the slave.

Reset
REQ-026 SHALL, on reset, set state=IDLE, cs_n=1, sclk=0, mosi=0, resp_valid=0, err=0, result=0 and req_ready=1 on the next edge.
REQ-027 SHALL abort an in-flight frame on reset: cs_n high and sclk low on the next edge, no resp_valid issued, and result keeps its cleared value.
REQ-028 SHALL give reset priority over a request presented in the same cycle (the request is not accepted).

Structure
REQ-029 SHALL provide package spi_shift_pkg holding the shift-mode enum, the FSM state enum and the constants HDR_BITS=8, TX_BITS=40, RX_BITS=32 and FRAME_BITS=72.
REQ-030 SHALL use one sub-module, spi_clk_gen: a CLK_DIV counter that emits one-cycle rise/fall strobes and the sclk level, enabled only in SHIFT.

Verification
REQ-031 SHALL verify a basic left shift: CLK_DIV=2, op_a=0x000000F0, nbits=4, mode=0, slave model returns 0x00000F00 -> mosi carries 0x04 then 0x000000F0, result=0x00000F00, resp_valid 293 cycles after accept.
REQ-032 SHALL verify an arithmetic right shift: op_a=0x80000000, nbits=31, mode=3, model returns 0xFFFFFFFF -> header 0x7F, result=0xFFFFFFFF, err=0.
REQ-033 SHALL verify an invalid mode: mode=6 -> no sclk edges, cs_n high throughout, resp_valid one cycle after accept with err=1 and result=0.
REQ-034 SHALL verify back-to-back requests: req_valid held high with two requests -> second accepted the cycle after the first RESP, exactly 72 rising sclk edges per cs_n-low window.
REQ-035 SHALL verify reset mid-frame: reset asserted during header bit 5 -> cs_n=1 and sclk=0 next cycle, no resp_valid, req_ready=1 after reset deasserts.
REQ-036 SHALL verify rotate by zero: op_a=0xDEADBEEF, nbits=0, mode=4, model echoes op_a -> header 0x80, result=0xDEADBEEF.

Source files
------------

// File: rtl/spi_shift_pkg.sv
// Shared types and frame constants for the SPI shift master.
// Shift-mode and FSM state enums, frame lengths, mode check.
package spi_shift_pkg;

  localparam int HDR_BITS   = 8;
  localparam int TX_BITS    = 40;
  localparam int RX_BITS    = 32;
  localparam int FRAME_BITS = 72;

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASL = 3'd2,
    SH_ASR = 3'd3,
    SH_ROL = 3'd4,
    SH_ROR = 3'd5
  } shift_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_RESP
  } state_e;

  function automatic logic mode_ok(
    input logic [2:0] m
  );
    return m <= 3'(SH_ROR);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: CLK_DIV cycles per half period, idles low.
// Ports: clock, reset, en in; sclk level, rise/fall strobes out.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  assign tick = en && (cnt_q == LAST);

  // Strobes coincide with the edge on which sclk changes level.
  assign rise = tick && !sclk_q;
  assign fall = tick && sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_shift_master.sv
// SPI mode-0 master sending {mode,nbits},op_a and reading a result.
// Ports: req_valid/ready + op_a/nbits/mode in; resp_valid/result/err out; SPI pins.
module spi_shift_master #(
  parameter int REG_WIDTH = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [4:0]           nbits,
  input  logic [2:0]           mode,
  output logic                 resp_valid,
  output logic [REG_WIDTH-1:0] result,
  output logic                 err,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  import spi_shift_pkg::*;

  localparam int OPW = TX_BITS - HDR_BITS;
  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0]  LAST_PH  = CW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          ph_q, ph_d;
  logic [BCW-1:0]         bit_q, bit_d;
  logic [TX_BITS-1:0]     tx_q, tx_d;
  logic [RX_BITS-1:0]     rx_q, rx_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_n_q, cs_n_d;
  logic                   err_q, err_d;
  logic [REG_WIDTH-1:0]   result_q, result_d;

  logic [HDR_BITS-1:0]    hdr;
  logic                   shift_en;
  logic                   s_rise;
  logic                   s_fall;

  assign hdr      = {mode, nbits};
  assign shift_en = (state_q == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clock (clock),
    .reset (reset),
    .en    (shift_en),
    .sclk  (sclk),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign result     = result_q;
  assign err        = err_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (mode_ok(mode)) begin
            state_d = ST_CS_SETUP;
            tx_d    = {hdr, OPW'(op_a)};
            mosi_d  = hdr[HDR_BITS-1];
            ph_d    = '0;
            bit_d   = '0;
            cs_n_d  = 1'b0;
          end else begin
            state_d  = ST_RESP;
            err_d    = 1'b1;
            result_d = '0;
          end
        end
      end
      ST_CS_SETUP: begin
        if (ph_q == LAST_PH) begin
          ph_d    = '0;
          state_d = ST_SHIFT;
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        // Early rises shift header-time junk in; it falls
        // off the top before the last read bit lands.
        if (s_rise) begin
          rx_d = {rx_q[RX_BITS-2:0], miso};
        end
        if (s_fall) begin
          tx_d   = {tx_q[TX_BITS-2:0], 1'b0};
          mosi_d = tx_q[TX_BITS-2];
          bit_d  = bit_q + BCW'(1);
          if (bit_q == LAST_BIT) begin
            state_d = ST_CS_HOLD;
            mosi_d  = 1'b0;
            ph_d    = '0;
          end
        end
      end
      ST_CS_HOLD: begin
        if (ph_q == LAST_PH) begin
          ph_d     = '0;
          state_d  = ST_RESP;
          cs_n_d   = 1'b1;
          err_d    = 1'b0;
          result_d = REG_WIDTH'(rx_q);
        end else begin
          ph_d = ph_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_spi_shift_master.sv
// Scoreboard bench for spi_shift_master with a behavioural SPI slave.
// Directed spec cases plus randomized requests.
module tb_spi_shift_master;

  localparam int CD = 2;
  localparam int LAT = 146 * CD + 1;

  typedef struct {
    logic        err;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [4:0]  nbits;
  logic [2:0]  mode;
  logic        resp_valid;
  logic [31:0] result;
  logic        err;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  exp_t        exp_q[$];
  logic [39:0] frm_q[$];
  int          acc_q[$];

  logic        aborting = 1'b0;
  logic        b2b_arm  = 1'b0;
  logic        b2b_done = 1'b0;
  int          b2b_base = 0;
  int          n_resp   = 0;
  int          last_resp = 0;

  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        in_win    = 1'b0;
  int          rises     = 0;
  int          falls     = 0;
  int          stray     = 0;
  logic [71:0] rxf;
  logic [31:0] sresp;

  spi_shift_master #(
    .REG_WIDTH (32),
    .CLK_DIV   (CD)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a       (op_a),
    .nbits      (nbits),
    .mode       (mode),
    .resp_valid (resp_valid),
    .result     (result),
    .err        (err),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // What a correct slave computes from the received header.
  function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                            input logic [4:0]  n,
                                            input logic [2:0]  m);
    logic [63:0] t;
    case (m)
      3'd0, 3'd2: return a << n;
      3'd1:       return a >> n;
      3'd3:       return $signed(a) >>> n;
      3'd4: begin
        t = {a, a} << n;
        return t[63:32];
      end
      3'd5: begin
        t = {a, a} >> n;
        return t[31:0];
      end
      default:    return 32'h0;
    endcase
  endfunction

  // Monitor and slave share one sampling point away from the edge.
  always @(negedge clk) begin
    exp_t e;
    int   a0;
    if (reset) acc_q.delete();
    if (resp_valid) begin
      n_resp++;
      last_resp = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("err", err, e.err);
        if (acc_q.size() > 0) begin
          a0 = acc_q.pop_front();
          chk("latency", cyc - a0, e.err ? 1 : LAT);
        end else begin
          chk("latency_no_accept", 0, 1);
        end
      end
    end
    if (req_valid && req_ready && !reset) begin
      acc_q.push_back(cyc);
      if (b2b_arm && !b2b_done && n_resp > b2b_base) begin
        chk("b2b_gap", cyc - last_resp, 1);
        b2b_done = 1'b1;
      end
    end
    if (cs_n && sclk && !prev_sclk) stray++;
    if (!cs_n && prev_cs) begin
      in_win = 1'b1;
      rises  = 0;
      falls  = 0;
      rxf    = '0;
      miso   = 1'($urandom);
    end
    if (in_win && sclk && !prev_sclk) begin
      rxf = {rxf[70:0], mosi};
      rises++;
    end
    if (in_win && !sclk && prev_sclk) begin
      if (falls == 39)
        sresp = ref_shift(rxf[31:0], rxf[36:32], rxf[39:37]);
      if (falls >= 39 && falls <= 70)
        miso = sresp[31 - (falls - 39)];
      else
        miso = 1'($urandom);
      falls++;
    end
    if (in_win && cs_n && !prev_cs) begin
      in_win = 1'b0;
      if (aborting) begin
        if (frm_q.size() > 0) void'(frm_q.pop_front());
      end else if (frm_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        chk("mosi_tx", rxf[71:32], frm_q.pop_front());
        chk("mosi_rd_low", rxf[31:0], 0);
        chk("sclk_rises", rises, 72);
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic issue(input logic [31:0] a,
                       input logic [4:0]  n,
                       input logic [2:0]  m);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    op_a      = a;
    nbits     = n;
    mode      = m;
    req_valid = 1'b1;
    e.err = (m > 3'd5);
    e.res = e.err ? 32'h0 : ref_shift(a, n, m);
    exp_q.push_back(e);
    if (!e.err) frm_q.push_back({m, n, a});
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready && !reset) break;
      t++;
      if (t > 2000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || frm_q.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      chk("drain_timeout", 0, 1);
      exp_q.delete();
      frm_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [2:0] m;
    reset     = 1'b1;
    req_valid = 1'b0;
    op_a      = '0;
    nbits     = '0;
    mode      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(32'h0000_00F0, 5'd4, 3'd0);
    req_valid = 1'b0;
    drain();
    issue(32'h8000_0000, 5'd31, 3'd3);
    req_valid = 1'b0;
    drain();
    issue(32'hDEAD_BEEF, 5'd0, 3'd4);
    req_valid = 1'b0;
    drain();
    issue(32'h1234_5678, 5'd3, 3'd6);
    req_valid = 1'b0;
    drain();
    issue(32'hCAFE_F00D, 5'd9, 3'd7);
    req_valid = 1'b0;
    drain();

    b2b_base = n_resp;
    b2b_arm  = 1'b1;
    issue($urandom, 5'($urandom), 3'd1);
    issue($urandom, 5'($urandom), 3'd5);
    req_valid = 1'b0;
    drain();
    chk("b2b_checked", b2b_done, 1);
    b2b_arm = 1'b0;

    aborting = 1'b1;
    issue(32'h55AA_33CC, 5'd9, 3'd2);
    req_valid = 1'b0;
    t = 0;
    while (!(in_win && rises == 6) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_bit5", t < 1000, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    t = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) t++;
    end
    chk("abort_no_resp", t, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_frame_closed", frm_q.size(), 0);
    aborting = 1'b0;

    for (int i = 0; i < 16; i++) begin
      m = 3'($urandom_range(0, 7));
      issue($urandom, 5'($urandom), m);
      if ($urandom_range(0, 2) == 0)
        issue($urandom, 5'($urandom), 3'($urandom_range(0, 7)));
      req_valid = 1'b0;
      drain();
    end

    repeat (4) @(negedge clk);
    chk("stray_sclk", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
